// File: rtl/vending_pkg.sv
// Shared types for the multi-product vending controller:
// FSM states, coin codes and the coin value lookup.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_3    = 2'b11;

    function automatic int unsigned coin_value(
        input logic [1:0]  m,
        input int unsigned v1,
        input int unsigned v2,
        input int unsigned v3
    );
        int unsigned v;
        v = 0;
        case (m)
            COIN_1:  v = v1;
            COIN_2:  v = v2;
            COIN_3:  v = v3;
            default: v = 0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vending_fsm_multi_if.sv
// Bundle between the vending controller and the coin acceptor,
// keypad, dispenser and change hopper.
interface vending_fsm_multi_if #(
    parameter int unsigned N_PROD   = 2,
    parameter int unsigned CREDIT_W = 4
);
    logic [1:0]          moneda;
    logic [N_PROD-1:0]   comprar;
    logic                cancelar;
    logic [N_PROD-1:0]   listo;
    logic [N_PROD-1:0]   vend;
    logic                cambio;
    logic                rechazo;
    logic [CREDIT_W-1:0] total;
    logic                ocupado;

    modport master (
        output moneda, comprar, cancelar,
        input  listo, vend, cambio, rechazo, total, ocupado
    );

    modport slave (
        input  moneda, comprar, cancelar,
        output listo, vend, cambio, rechazo, total, ocupado
    );
endinterface

// File: rtl/vend_arbiter.sv
// Fixed-priority purchase arbiter: the lowest-index product that
// is both requested and affordable gets a one-hot grant.
module vend_arbiter #(
    parameter int unsigned N_PROD   = 2,
    parameter int unsigned CREDIT_W = 4
) (
    input  logic [N_PROD-1:0]          comprar,
    input  logic [CREDIT_W-1:0]        total,
    input  logic [N_PROD*CREDIT_W-1:0] prices,
    output logic [N_PROD-1:0]          grant,
    output logic                       any
);

    // Scan from product 0 upward; first affordable request wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int i = 0; i < int'(N_PROD); i++) begin
            if (!any && comprar[i] &&
                total >= prices[i*CREDIT_W +: CREDIT_W]) begin
                grant[i] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vending_fsm_multi.sv
// N-product vending controller: saturating credit, purchase with
// deduction, cancel/refund and unit-by-unit change dispensing.
module vending_fsm_multi
    import vending_pkg::*;
#(
    parameter int unsigned N_PROD   = 2,
    parameter int unsigned CREDIT_W = 4,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {4'd3, 4'd2},
    parameter int unsigned COIN_V1  = 2,
    parameter int unsigned COIN_V2  = 3,
    parameter int unsigned COIN_V3  = 4,
    parameter bit          AUTO_CHG = 1'b1
) (
    input logic clk,
    input logic reset,
    vending_fsm_multi_if.slave bus
);

    localparam logic [CREDIT_W:0] MAX_EXT = {1'b0, {CREDIT_W{1'b1}}};

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] total_q, total_d;
    logic [N_PROD-1:0]   vend_q, vend_d;
    logic                cambio_q, cambio_d;
    logic                rechazo_q, rechazo_d;
    logic                ocupado_q, ocupado_d;

    logic [N_PROD-1:0]   grant;
    logic                any_grant;
    logic [CREDIT_W-1:0] sel_price;
    logic [N_PROD-1:0]   listo_c;
    logic                coin_in;
    logic [CREDIT_W:0]   coin_amt;
    logic [CREDIT_W:0]   sum;
    logic                fits;

    vend_arbiter #(
        .N_PROD   (N_PROD),
        .CREDIT_W (CREDIT_W)
    ) u_arb (
        .comprar (bus.comprar),
        .total   (total_q),
        .prices  (PRICES),
        .grant   (grant),
        .any     (any_grant)
    );

    assign coin_in  = (bus.moneda != COIN_NONE);
    assign coin_amt = (CREDIT_W+1)'(coin_value(bus.moneda,
                          COIN_V1, COIN_V2, COIN_V3));
    assign sum      = {1'b0, total_q} + coin_amt;
    assign fits     = (sum <= MAX_EXT);

    // Price of the granted product and the per-product ready decode.
    always_comb begin
        sel_price = '0;
        listo_c   = '0;
        for (int i = 0; i < int'(N_PROD); i++) begin
            if (grant[i])
                sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
            listo_c[i] = (state_q == CREDIT) &&
                (total_q >= PRICES[i*CREDIT_W +: CREDIT_W]);
        end
    end

    // Next state, credit update and next-cycle output pulses.
    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        vend_d    = '0;
        cambio_d  = 1'b0;
        rechazo_d = 1'b0;
        case (state_q)
            IDLE, CREDIT: begin
                if (state_q == CREDIT && bus.cancelar) begin
                    state_d   = CHANGE;
                    rechazo_d = coin_in;
                end else if (state_q == CREDIT && any_grant) begin
                    state_d   = VEND;
                    vend_d    = grant;
                    total_d   = total_q - sel_price;
                    rechazo_d = coin_in;
                end else if (coin_in) begin
                    if (fits) begin
                        total_d = sum[CREDIT_W-1:0];
                        if (sum != '0)
                            state_d = CREDIT;
                    end else begin
                        rechazo_d = 1'b1;
                    end
                end
            end
            VEND: begin
                rechazo_d = coin_in;
                if (total_q == '0)
                    state_d = IDLE;
                else if (AUTO_CHG)
                    state_d = CHANGE;
                else
                    state_d = CREDIT;
            end
            CHANGE: begin
                rechazo_d = coin_in;
                if (total_q != '0) begin
                    cambio_d = 1'b1;
                    total_d  = total_q - 1'b1;
                    if (total_q == CREDIT_W'(1))
                        state_d = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ocupado_d = (state_d == VEND) || (state_d == CHANGE);
    end

    // State, credit and registered output pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            total_q   <= '0;
            vend_q    <= '0;
            cambio_q  <= 1'b0;
            rechazo_q <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            vend_q    <= vend_d;
            cambio_q  <= cambio_d;
            rechazo_q <= rechazo_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign bus.listo   = listo_c;
    assign bus.vend    = vend_q;
    assign bus.cambio  = cambio_q;
    assign bus.rechazo = rechazo_q;
    assign bus.total   = total_q;
    assign bus.ocupado = ocupado_q;

endmodule

// File: tb/tb_vending_fsm_multi.sv
// Bench for vending_fsm_multi: table of input/expected-output
// vectors through a scoreboard queue plus hand-written corner cases.
module tb_vending_fsm_multi;

    logic clk;
    logic reset;

    int checks;
    int errors;

    typedef struct {
        logic [1:0] vend;
        logic       cambio;
        logic       rech;
        logic [3:0] total;
        logic       ocup;
        logic [1:0] listo;
    } exp_t;

    typedef struct {
        logic [1:0] m;
        logic [1:0] c;
        logic       x;
        exp_t       e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    vending_fsm_multi_if #(.N_PROD(2), .CREDIT_W(4)) bus ();

    vending_fsm_multi dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0h exp %0h",
                     nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input exp_t e);
        chk("vend",    idx, 32'(bus.vend),    32'(e.vend));
        chk("cambio",  idx, 32'(bus.cambio),  32'(e.cambio));
        chk("rechazo", idx, 32'(bus.rechazo), 32'(e.rech));
        chk("total",   idx, 32'(bus.total),   32'(e.total));
        chk("ocupado", idx, 32'(bus.ocupado), 32'(e.ocup));
        chk("listo",   idx, 32'(bus.listo),   32'(e.listo));
    endtask

    task automatic add(input int m, input int c, input int x,
                       input int v, input int cb, input int r,
                       input int t, input int o, input int l);
        vec_t w;
        w.m       = 2'(m);
        w.c       = 2'(c);
        w.x       = 1'(x);
        w.e.vend  = 2'(v);
        w.e.cambio= 1'(cb);
        w.e.rech  = 1'(r);
        w.e.total = 4'(t);
        w.e.ocup  = 1'(o);
        w.e.listo = 2'(l);
        vecs.push_back(w);
    endtask

    // Drive one cycle of inputs, expect e after the next edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        sb.push_back(v.e);
        bus.moneda   = v.m;
        bus.comprar  = v.c;
        bus.cancelar = v.x;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_all(idx, e);
    endtask

    function automatic vec_t idle_vec(input int cb, input int t,
                                      input int o);
        vec_t w;
        w.m        = 2'b00;
        w.c        = 2'b00;
        w.x        = 1'b0;
        w.e.vend   = 2'b00;
        w.e.cambio = 1'(cb);
        w.e.rech   = 1'b0;
        w.e.total  = 4'(t);
        w.e.ocup   = 1'(o);
        w.e.listo  = 2'b00;
        return w;
    endfunction

    initial begin
        exp_t z;
        checks = 0;
        errors = 0;
        z = '{vend: 2'b00, cambio: 1'b0, rech: 1'b0,
              total: 4'd0, ocup: 1'b0, listo: 2'b00};

        // cancel in IDLE is ignored
        add(0,0,1, 0,0,0, 0,0,0);
        // coin 01, buy product 0, held comprar + coin in VEND
        add(1,0,0, 0,0,0, 2,0,1);
        add(0,1,0, 1,0,0, 0,1,0);
        add(1,1,0, 0,0,1, 0,0,0);
        add(0,0,0, 0,0,0, 0,0,0);
        // coins 11,10 -> 7, buy product 1, 4 change pulses
        add(3,0,0, 0,0,0, 4,0,3);
        add(2,0,0, 0,0,0, 7,0,3);
        add(0,2,0, 2,0,0, 4,1,0);
        add(0,0,0, 0,0,0, 4,1,0);
        add(0,0,0, 0,1,0, 3,1,0);
        add(1,0,0, 0,1,1, 2,1,0);
        add(0,0,0, 0,1,0, 1,1,0);
        add(0,0,0, 0,1,0, 0,0,0);
        add(0,0,0, 0,0,0, 0,0,0);
        // total 3, comprar 11 + coin -> vend[0], coin rejected
        add(2,0,0, 0,0,0, 3,0,3);
        add(1,3,0, 1,0,1, 1,1,0);
        add(0,0,0, 0,0,0, 1,1,0);
        add(0,0,0, 0,1,0, 0,0,0);
        add(0,0,0, 0,0,0, 0,0,0);
        // unaffordable request ignored, coin beats it, then vends
        add(1,0,0, 0,0,0, 2,0,1);
        add(0,2,0, 0,0,0, 2,0,1);
        add(1,2,0, 0,0,0, 4,0,3);
        add(0,2,0, 2,0,0, 1,1,0);
        add(0,2,0, 0,0,0, 1,1,0);
        add(0,0,0, 0,1,0, 0,0,0);
        add(0,0,0, 0,0,0, 0,0,0);
        // total 5, cancel + coin -> rejected, 5 pulses
        add(1,0,0, 0,0,0, 2,0,1);
        add(2,0,0, 0,0,0, 5,0,3);
        add(1,0,1, 0,0,1, 5,1,0);
        add(0,0,0, 0,1,0, 4,1,0);
        add(0,0,0, 0,1,0, 3,1,0);
        add(0,0,0, 0,1,0, 2,1,0);
        add(0,0,0, 0,1,0, 1,1,0);
        add(0,0,0, 0,1,0, 0,0,0);
        add(0,0,0, 0,0,0, 0,0,0);
        // saturation: 12, reject 11, accept 10 -> 15, reject, cancel
        add(3,0,0, 0,0,0, 4,0,3);
        add(3,0,0, 0,0,0, 8,0,3);
        add(3,0,0, 0,0,0, 12,0,3);
        add(3,0,0, 0,0,1, 12,0,3);
        add(2,0,0, 0,0,0, 15,0,3);
        add(1,0,0, 0,0,1, 15,0,3);
        add(0,0,1, 0,0,0, 15,1,0);

        bus.moneda   = 2'b00;
        bus.comprar  = 2'b00;
        bus.cancelar = 1'b0;
        reset = 1'b0;
        #3;
        chk_all(-1, z);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // drain of 15 after the cancel above
        for (int k = 14; k >= 0; k--)
            apply(idle_vec(1, k, (k != 0) ? 1 : 0), 100 + k);
        apply(idle_vec(0, 0, 0), 200);

        // reset while in CHANGE with total 3
        begin
            vec_t w;
            w = idle_vec(0, 4, 0);
            w.m = 2'b11;
            w.e.listo = 2'b11;
            apply(w, 300);
            w = idle_vec(0, 4, 1);
            w.x = 1'b1;
            apply(w, 301);
            apply(idle_vec(1, 3, 1), 302);
        end
        #2;
        reset = 1'b0;
        #1;
        chk_all(400, z);
        @(posedge clk);
        #1;
        chk_all(401, z);
        reset = 1'b1;
        apply(idle_vec(0, 0, 0), 402);
        apply(idle_vec(0, 0, 0), 403);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
